// File: rtl/freq_tick_monitor.sv
// freq_tick_monitor
//   Receives the divider's slow output in the CLK domain. It synchronises
//   DIV_IN and emits a one-cycle TICK per rising edge. It measures the period
//   between ticks and declares lock after LOCK_COUNT consecutive periods of
//   EXP_PERIOD. It also flags a period mismatch after lock and a stalled
//   divider (counter saturation).
//
//   Optional build macro MONITOR_DUTY_EN adds HIGH_TIME / DUTY_ERR
//   (high-phase measurement and duty-cycle check while locked).
//
// Ports:
//   CLK          system clock, all state on rising edge
//   RST          asynchronous active-high reset
//   DIV_IN       divided clock, treated as asynchronous data
//   TICK         one-CLK pulse per synchronised rising edge of DIV_IN
//   PERIOD       last measured period in CLK cycles
//   PERIOD_VALID one-cycle pulse when PERIOD updates
//   LOCKED       period stable at EXP_PERIOD
//   ERR          sticky: mismatch while locked or counter overflow
//   OVF          sticky: period counter saturated
//   HIGH_TIME    (MONITOR_DUTY_EN) high cycles of the last completed period
//   DUTY_ERR     (MONITOR_DUTY_EN) sticky: high time off by >1 while locked
module freq_tick_monitor #(
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned EXP_PERIOD  = 28,
  parameter int unsigned LOCK_COUNT  = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             DIV_IN,
  output logic             TICK,
  output logic [CNT_W-1:0] PERIOD,
  output logic             PERIOD_VALID,
  output logic             LOCKED,
  output logic             ERR,
  output logic             OVF
`ifdef MONITOR_DUTY_EN
  ,
  output logic [CNT_W-1:0] HIGH_TIME,
  output logic             DUTY_ERR
`endif
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_PRE = CNT_MAX - CNT_ONE;
  localparam logic [CNT_W-1:0] EXP_VAL = CNT_W'(EXP_PERIOD);
  localparam logic [3:0]       LCK_VAL = 4'(LOCK_COUNT);

  typedef enum logic [1:0] {
    SEEK,
    ACQUIRE,
    LOCK,
    FAULT
  } state_t;

  state_t               state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                 prev_q;
  logic                 sync_out;
  logic                 rise;
  logic [CNT_W-1:0]     cnt_q;
  logic [3:0]           mc_q, mc_d;
  logic [3:0]           mc_inc;
  logic                 match;
  logic                 sat_hit;
  logic                 upd;
  logic                 locked_d;
  logic                 err_set;
  logic                 ovf_set;

  // Synchroniser chain followed by an edge-detect flop.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], DIV_IN};
      prev_q <= sync_out;
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign rise     = sync_out & ~prev_q;

  // TICK is registered, so it lands SYNC_STAGES+1 edges after DIV_IN is
  // first sampled high.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      TICK <= 1'b0;
    end else begin
      TICK <= rise;
    end
  end

  // Period counter: restarts at 1 on a tick, so its value during the next
  // tick is the number of cycles between the two ticks. Saturates.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q <= '0;
    end else if (TICK) begin
      cnt_q <= CNT_ONE;
    end else if (cnt_q != CNT_MAX) begin
      cnt_q <= cnt_q + CNT_ONE;
    end
  end

  assign match   = (cnt_q == EXP_VAL);
  assign mc_inc  = mc_q + 4'd1;
  // Saturation is flagged on the edge that would take cnt to its maximum.
  // A tick on that same cycle restarts the counter instead and wins.
  assign sat_hit = ~TICK & (cnt_q == CNT_PRE);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= SEEK;
      mc_q    <= '0;
    end else begin
      state_q <= state_d;
      mc_q    <= mc_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mc_d     = mc_q;
    upd      = 1'b0;
    locked_d = LOCKED;
    err_set  = 1'b0;
    ovf_set  = 1'b0;
    case (state_q)
      SEEK: begin
        if (TICK) begin
          state_d = ACQUIRE;
        end
      end
      ACQUIRE, FAULT: begin
        if (TICK) begin
          upd = 1'b1;
          if (match) begin
            if (mc_inc == LCK_VAL) begin
              state_d  = LOCK;
              mc_d     = '0;
              locked_d = 1'b1;
            end else begin
              mc_d = mc_inc;
            end
          end else begin
            mc_d = '0;
          end
        end else if (sat_hit) begin
          ovf_set = 1'b1;
        end
      end
      LOCK: begin
        if (TICK) begin
          upd = 1'b1;
          if (!match) begin
            state_d  = FAULT;
            mc_d     = '0;
            locked_d = 1'b0;
            err_set  = 1'b1;
          end
        end else if (sat_hit) begin
          ovf_set  = 1'b1;
          state_d  = FAULT;
          mc_d     = '0;
          locked_d = 1'b0;
        end
      end
      default: begin
        state_d = SEEK;
        mc_d    = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      PERIOD       <= '0;
      PERIOD_VALID <= 1'b0;
      LOCKED       <= 1'b0;
      ERR          <= 1'b0;
      OVF          <= 1'b0;
    end else begin
      PERIOD_VALID <= upd;
      if (upd) begin
        PERIOD <= cnt_q;
      end
      LOCKED <= locked_d;
      if (err_set || ovf_set) begin
        ERR <= 1'b1;
      end
      if (ovf_set) begin
        OVF <= 1'b1;
      end
    end
  end

`ifdef MONITOR_DUTY_EN
  localparam logic [CNT_W-1:0] HALF_VAL = CNT_W'(EXP_PERIOD / 2);

  logic             fall;
  logic [CNT_W-1:0] hcnt_q;
  logic [CNT_W-1:0] dev;

  assign fall = ~sync_out & prev_q;
  assign dev  = (hcnt_q > HALF_VAL) ? (hcnt_q - HALF_VAL) : (HALF_VAL - hcnt_q);

  // High-phase counter: restarts on the rising edge, captured on the fall.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hcnt_q    <= '0;
      HIGH_TIME <= '0;
      DUTY_ERR  <= 1'b0;
    end else begin
      if (rise) begin
        hcnt_q <= CNT_ONE;
      end else if (sync_out && (hcnt_q != CNT_MAX)) begin
        hcnt_q <= hcnt_q + CNT_ONE;
      end
      if (fall) begin
        HIGH_TIME <= hcnt_q;
        if ((state_q == LOCK) && (dev > CNT_ONE)) begin
          DUTY_ERR <= 1'b1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_freq_tick_monitor.sv
module tb_freq_tick_monitor;

  logic       CLK = 1'b0;
  logic       RST;
  logic       DIV_IN;
  logic       TICK;
  logic [7:0] PERIOD;
  logic       PERIOD_VALID;
  logic       LOCKED;
  logic       ERR;
  logic       OVF;
`ifdef MONITOR_DUTY_EN
  logic [7:0] HIGH_TIME;
  logic       DUTY_ERR;
`endif

  typedef struct {
    logic [7:0] period;
    logic       locked;
    logic       err;
    logic       ovf;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   tick_cnt = 0;
  int   t0;

  freq_tick_monitor #(
    .CNT_W(8),
    .EXP_PERIOD(28),
    .LOCK_COUNT(4),
    .SYNC_STAGES(2)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .DIV_IN(DIV_IN),
    .TICK(TICK),
    .PERIOD(PERIOD),
    .PERIOD_VALID(PERIOD_VALID),
    .LOCKED(LOCKED),
    .ERR(ERR),
    .OVF(OVF)
`ifdef MONITOR_DUTY_EN
    ,
    .HIGH_TIME(HIGH_TIME),
    .DUTY_ERR(DUTY_ERR)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] p, input logic l, input logic e, input logic o);
    exp_t x;
    x.period = p;
    x.locked = l;
    x.err    = e;
    x.ovf    = o;
    q.push_back(x);
  endtask

  task automatic wave(input int hi, input int lo);
    DIV_IN = 1'b1;
    repeat (hi) @(negedge CLK);
    DIV_IN = 1'b0;
    repeat (lo) @(negedge CLK);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_tick"}, 32'(TICK), 32'd0);
    chk({tag, "_period"}, 32'(PERIOD), 32'd0);
    chk({tag, "_pvalid"}, 32'(PERIOD_VALID), 32'd0);
    chk({tag, "_locked"}, 32'(LOCKED), 32'd0);
    chk({tag, "_err"}, 32'(ERR), 32'd0);
    chk({tag, "_ovf"}, 32'(OVF), 32'd0);
  endtask

  // Scoreboard monitor: every PERIOD_VALID pops one expectation.
  always @(negedge CLK) begin
    exp_t e;
    if (TICK === 1'b1) tick_cnt++;
    if (RST === 1'b0 && PERIOD_VALID === 1'b1) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_valid actual period=%0d required no PERIOD_VALID", PERIOD);
      end else begin
        e = q.pop_front();
        if (PERIOD !== e.period || LOCKED !== e.locked || ERR !== e.err || OVF !== e.ovf) begin
          failures++;
          $display("FAIL period_sample actual p=%0d l=%0b e=%0b o=%0b required p=%0d l=%0b e=%0b o=%0b",
                   PERIOD, LOCKED, ERR, OVF, e.period, e.locked, e.err, e.ovf);
        end
      end
    end
  end

  initial begin
    RST    = 1'b1;
    DIV_IN = 1'b0;
    repeat (3) @(negedge CLK);
    chk_all_zero("reset");
    RST = 1'b0;
    repeat (5) @(negedge CLK);

    // First rising edge: TICK latency of 3 edges, width 1.
    DIV_IN = 1'b1;
    repeat (2) @(negedge CLK);
    chk("tick_early", 32'(TICK), 32'd0);
    @(negedge CLK);
    chk("tick_latency", 32'(TICK), 32'd1);
    @(negedge CLK);
    chk("tick_width", 32'(TICK), 32'd0);
    repeat (10) @(negedge CLK);
    DIV_IN = 1'b0;
    repeat (14) @(negedge CLK);

    // Acquire: four matching periods lock.
    push(8'd28, 1'b0, 1'b0, 1'b0); wave(14, 14);
    push(8'd28, 1'b0, 1'b0, 1'b0); wave(14, 14);
    push(8'd28, 1'b0, 1'b0, 1'b0); wave(14, 14);
    push(8'd28, 1'b1, 1'b0, 1'b0); wave(14, 14);
    chk("tick_count_no_fall", 32'(tick_cnt), 32'd5);
    chk("lock1_locked", 32'(LOCKED), 32'd1);
    chk("lock1_err", 32'(ERR), 32'd0);

    // Short period 27 after lock, then re-lock.
    push(8'd28, 1'b1, 1'b0, 1'b0); wave(13, 14);
    push(8'd27, 1'b0, 1'b1, 1'b0); wave(14, 14);
    push(8'd28, 1'b0, 1'b1, 1'b0); wave(14, 14);
    push(8'd28, 1'b0, 1'b1, 1'b0); wave(14, 14);
    push(8'd28, 1'b0, 1'b1, 1'b0); wave(14, 14);
    push(8'd28, 1'b1, 1'b1, 1'b0); wave(14, 14);
    chk("relock_locked", 32'(LOCKED), 32'd1);
    chk("relock_err", 32'(ERR), 32'd1);
    chk("relock_ovf", 32'(OVF), 32'd0);

    // Stalled divider: counter saturates.
    repeat (300) @(negedge CLK);
    chk("stall_ovf", 32'(OVF), 32'd1);
    chk("stall_err", 32'(ERR), 32'd1);
    chk("stall_locked", 32'(LOCKED), 32'd0);
    push(8'd255, 1'b0, 1'b1, 1'b1); wave(14, 14);
    push(8'd28, 1'b0, 1'b1, 1'b1); wave(14, 14);
    push(8'd28, 1'b0, 1'b1, 1'b1); wave(14, 14);
    push(8'd28, 1'b0, 1'b1, 1'b1); wave(14, 14);
    push(8'd28, 1'b1, 1'b1, 1'b1); wave(14, 14);
    chk("stall_relock", 32'(LOCKED), 32'd1);

    // Reset pulse in the low phase while locked.
    push(8'd28, 1'b1, 1'b1, 1'b1);
    DIV_IN = 1'b1;
    repeat (14) @(negedge CLK);
    DIV_IN = 1'b0;
    repeat (5) @(negedge CLK);
    RST = 1'b1;
    #1;
    chk_all_zero("midrst");
    @(negedge CLK);
    RST = 1'b0;
    repeat (8) @(negedge CLK);
    chk("midrst_queue", 32'(q.size()), 32'd0);
    wave(14, 14);
    push(8'd28, 1'b0, 1'b0, 1'b0); wave(14, 14);
    push(8'd28, 1'b0, 1'b0, 1'b0); wave(14, 14);
    push(8'd28, 1'b0, 1'b0, 1'b0); wave(14, 14);
    push(8'd28, 1'b1, 1'b0, 1'b0); wave(14, 14);
    chk("midrst_locked", 32'(LOCKED), 32'd1);
    chk("midrst_ovf", 32'(OVF), 32'd0);

    // One-cycle glitch in the low phase: periods 19 and 9.
    push(8'd28, 1'b1, 1'b0, 1'b0);
    push(8'd19, 1'b0, 1'b1, 1'b0);
    t0 = tick_cnt;
    DIV_IN = 1'b1;
    repeat (14) @(negedge CLK);
    DIV_IN = 1'b0;
    repeat (5) @(negedge CLK);
    DIV_IN = 1'b1;
    @(negedge CLK);
    DIV_IN = 1'b0;
    repeat (8) @(negedge CLK);
    chk("glitch_ticks", 32'(tick_cnt - t0), 32'd2);
    push(8'd9, 1'b0, 1'b1, 1'b0); wave(14, 14);
    push(8'd28, 1'b0, 1'b1, 1'b0); wave(14, 10);
    chk("glitch_locked", 32'(LOCKED), 32'd0);
    chk("glitch_err", 32'(ERR), 32'd1);

`ifdef MONITOR_DUTY_EN
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    chk("duty_rst_high", 32'(HIGH_TIME), 32'd0);
    chk("duty_rst_err", 32'(DUTY_ERR), 32'd0);
    q.delete();
    wave(14, 14);
    push(8'd28, 1'b0, 1'b0, 1'b0); wave(14, 14);
    push(8'd28, 1'b0, 1'b0, 1'b0); wave(14, 14);
    push(8'd28, 1'b0, 1'b0, 1'b0); wave(14, 14);
    push(8'd28, 1'b1, 1'b0, 1'b0); wave(14, 14);
    chk("duty_high14", 32'(HIGH_TIME), 32'd14);
    chk("duty_ok", 32'(DUTY_ERR), 32'd0);
    push(8'd28, 1'b1, 1'b0, 1'b0); wave(17, 11);
    chk("duty_high17", 32'(HIGH_TIME), 32'd17);
    chk("duty_err", 32'(DUTY_ERR), 32'd1);
    push(8'd28, 1'b1, 1'b0, 1'b0); wave(14, 6);
`endif

    repeat (4) @(negedge CLK);
    chk("final_queue_empty", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
